// File: rtl/fetch_stage.sv
// Fetch stage: PC register plus direct-mapped BTB prediction; imem_addr -> fetch_dec_reg in one cycle.
// stall holds PC and output; redirect beats stall and injects a bubble; BTB trains on upd_en regardless.
module fetch_stage #(
  parameter logic [31:0] RESET_PC    = 32'h0000_0000,
  parameter int          BTB_ENTRIES = 16
) (
  input  logic        clk,
  input  logic        rstn,
  input  logic        stall,
  input  logic        redirect_en,
  input  logic [31:0] redirect_pc,
  input  logic        upd_en,
  input  logic [31:0] upd_pc,
  input  logic        upd_taken,
  input  logic [31:0] upd_target,
  output logic [31:0] imem_addr,
  input  logic [31:0] imem_rdata,
  output logic [64:0] fetch_dec_reg
);

  localparam int IDX  = $clog2(BTB_ENTRIES);
  localparam int TAGW = 30 - IDX;

  logic [31:0]     pc;
  logic            btb_vld [BTB_ENTRIES];
  logic [TAGW-1:0] btb_tag [BTB_ENTRIES];
  logic [31:0]     btb_tgt [BTB_ENTRIES];
  logic [1:0]      btb_ctr [BTB_ENTRIES];

  logic [IDX-1:0]  lk_idx;
  logic [IDX-1:0]  up_idx;
  logic [TAGW-1:0] lk_tag;
  logic [TAGW-1:0] up_tag;
  logic            lk_hit;
  logic            up_hit;
  logic            pred;
  logic [31:0]     next_pc;
  logic            unused_bits;

  // Word-alignment bits of incoming addresses are never stored.
  assign unused_bits = ^{redirect_pc[1:0], upd_pc[1:0], upd_target[1:0]};

  assign lk_idx  = pc[IDX+1:2];
  assign lk_tag  = pc[31:IDX+2];
  assign up_idx  = upd_pc[IDX+1:2];
  assign up_tag  = upd_pc[31:IDX+2];

  assign lk_hit  = btb_vld[lk_idx] && (btb_tag[lk_idx] == lk_tag);
  assign up_hit  = btb_vld[up_idx] && (btb_tag[up_idx] == up_tag);
  assign pred    = lk_hit && btb_ctr[lk_idx][1];
  assign next_pc = pred ? btb_tgt[lk_idx] : pc + 32'd4;

  assign imem_addr = pc;

  always_ff @(posedge clk or negedge rstn) begin
    if (!rstn) begin
      pc            <= {RESET_PC[31:2], 2'b00};
      fetch_dec_reg <= '0;
    end else if (redirect_en) begin
      pc            <= {redirect_pc[31:2], 2'b00};
      fetch_dec_reg <= '0;
    end else if (!stall) begin
      pc            <= next_pc;
      fetch_dec_reg <= {imem_rdata, pc, pred};
    end
  end

  // Lookup above reads pre-edge contents, so a same-index update shows up next cycle.
  always_ff @(posedge clk or negedge rstn) begin
    if (!rstn) begin
      for (int i = 0; i < BTB_ENTRIES; i++) begin
        btb_vld[i] <= 1'b0;
        btb_tag[i] <= '0;
        btb_tgt[i] <= '0;
        btb_ctr[i] <= 2'b01;
      end
    end else if (upd_en) begin
      if (up_hit) begin
        if (upd_taken) begin
          if (btb_ctr[up_idx] != 2'b11) btb_ctr[up_idx] <= btb_ctr[up_idx] + 2'b01;
          btb_tgt[up_idx] <= {upd_target[31:2], 2'b00};
        end else if (btb_ctr[up_idx] != 2'b00) begin
          btb_ctr[up_idx] <= btb_ctr[up_idx] - 2'b01;
        end
      end else if (upd_taken) begin
        btb_vld[up_idx] <= 1'b1;
        btb_tag[up_idx] <= up_tag;
        btb_tgt[up_idx] <= {upd_target[31:2], 2'b00};
        btb_ctr[up_idx] <= 2'b10;
      end
    end
  end

endmodule

// File: tb/tb_fetch_stage.sv
// Bench for fetch_stage: directed spec scenarios plus random traffic against a queue-based scoreboard.
module tb_fetch_stage;

  localparam logic [31:0] RST_PC = 32'h0000_0000;
  localparam int          N      = 16;
  localparam logic [31:0] WIN    = 32'd4 * N;

  logic        clk = 1'b0;
  logic        rstn = 1'b0;
  logic        stall = 1'b0;
  logic        redirect_en = 1'b0;
  logic [31:0] redirect_pc = '0;
  logic        upd_en = 1'b0;
  logic [31:0] upd_pc = '0;
  logic        upd_taken = 1'b0;
  logic [31:0] upd_target = '0;
  logic [31:0] imem_addr;
  logic [31:0] imem_rdata;
  logic [64:0] fetch_dec_reg;

  fetch_stage #(.RESET_PC(RST_PC), .BTB_ENTRIES(N)) dut (
    .clk(clk), .rstn(rstn), .stall(stall),
    .redirect_en(redirect_en), .redirect_pc(redirect_pc),
    .upd_en(upd_en), .upd_pc(upd_pc), .upd_taken(upd_taken), .upd_target(upd_target),
    .imem_addr(imem_addr), .imem_rdata(imem_rdata), .fetch_dec_reg(fetch_dec_reg)
  );

  always #5 clk = ~clk;

  function automatic logic [31:0] mem_word(input logic [31:0] a);
    return {a[15:0], 16'h0013};
  endfunction

  assign imem_rdata = mem_word(imem_addr);

  // Reference model: BTB as plain arrays indexed by word address modulo N.
  bit          mv   [N];
  logic [31:0] mtag [N];
  logic [31:0] mtgt [N];
  int          mctr [N];
  logic [31:0] mpc;
  logic [64:0] mfdr;

  typedef struct packed {
    logic [64:0] fdr;
    logic [31:0] pc;
  } exp_t;
  exp_t q[$];

  int nvec = 0;
  int nerr = 0;

  task automatic chk(input string nm, input logic [64:0] act, input logic [64:0] exp);
    nvec++;
    if (act !== exp) begin
      nerr++;
      $display("FAIL %s: got %h expected %h at %0t", nm, act, exp, $time);
    end
  endtask

  task automatic model_reset();
    mpc  = RST_PC;
    mfdr = '0;
    for (int i = 0; i < N; i++) begin
      mv[i]   = 1'b0;
      mctr[i] = 1;
    end
  endtask

  task automatic step(input bit st, input bit rd, input logic [31:0] rpc,
                      input bit ue, input logic [31:0] upc, input bit ut, input logic [31:0] utg);
    int   li;
    int   ui;
    bit   p;
    exp_t e;
    @(negedge clk);
    rstn = 1'b1; stall = st; redirect_en = rd; redirect_pc = rpc;
    upd_en = ue; upd_pc = upc; upd_taken = ut; upd_target = utg;
    li = int'((mpc / 32'd4) % N);
    p  = mv[li] && (mtag[li] == mpc / WIN) && (mctr[li] >= 2);
    if (rd) begin
      mfdr = '0;
      mpc  = rpc & ~32'h3;
    end else if (!st) begin
      mfdr = {mem_word(mpc), mpc, p};
      mpc  = p ? mtgt[li] : mpc + 32'd4;
    end
    if (ue) begin
      ui = int'((upc / 32'd4) % N);
      if (mv[ui] && mtag[ui] == upc / WIN) begin
        if (ut) begin
          mctr[ui] = (mctr[ui] < 3) ? mctr[ui] + 1 : 3;
          mtgt[ui] = utg & ~32'h3;
        end else begin
          mctr[ui] = (mctr[ui] > 0) ? mctr[ui] - 1 : 0;
        end
      end else if (ut) begin
        mv[ui] = 1'b1; mtag[ui] = upc / WIN; mtgt[ui] = utg & ~32'h3; mctr[ui] = 2;
      end
    end
    e.fdr = mfdr;
    e.pc  = mpc;
    q.push_back(e);
  endtask

  task automatic idle();
    step(0, 0, 32'h0, 0, 32'h0, 0, 32'h0);
  endtask

  task automatic redir(input logic [31:0] a);
    step(0, 1, a, 0, 32'h0, 0, 32'h0);
  endtask

  task automatic upd(input logic [31:0] a, input bit t, input logic [31:0] tg);
    step(0, 0, 32'h0, 1, a, t, tg);
  endtask

  task automatic after_edge();
    @(posedge clk);
    #2;
  endtask

  // Monitor: every scheduled edge has one expected entry waiting in the queue.
  initial begin
    exp_t e;
    forever begin
      @(posedge clk);
      #1;
      if (q.size() > 0) begin
        e = q.pop_front();
        chk("sb_fetch_dec_reg", fetch_dec_reg, e.fdr);
        chk("sb_imem_addr", {33'h0, imem_addr}, {33'h0, e.pc});
      end
    end
  end

  initial begin
    logic [64:0] held;
    model_reset();
    #3;
    chk("reset_fdr", fetch_dec_reg, 65'h0);
    chk("reset_pc", {33'h0, imem_addr}, {33'h0, RST_PC});

    // Reset release, sequential fetch.
    idle(); after_edge();
    chk("first_fetch", fetch_dec_reg, {32'h0000_0013, 32'h0, 1'b0});
    idle(); after_edge();
    chk("second_pc_field", {33'h0, fetch_dec_reg[32:1]}, 65'h4);

    // Stall three cycles at PC 8.
    held = fetch_dec_reg;
    for (int i = 0; i < 3; i++) begin
      step(1, 0, 32'h0, 0, 32'h0, 0, 32'h0); after_edge();
      chk("stall_addr", {33'h0, imem_addr}, 65'h8);
      chk("stall_hold", fetch_dec_reg, held);
    end
    idle(); after_edge();
    chk("stall_release_pc", {33'h0, fetch_dec_reg[32:1]}, 65'h8);

    // Redirect wins over stall.
    step(1, 1, 32'h40, 0, 32'h0, 0, 32'h0); after_edge();
    chk("redir_bubble", fetch_dec_reg, 65'h0);
    chk("redir_addr", {33'h0, imem_addr}, 65'h40);

    // Train taken, predict, then train down.
    upd(32'h10, 1, 32'h80);
    redir(32'h10);
    idle(); after_edge();
    chk("btb_pred_taken", {64'h0, fetch_dec_reg[0]}, 65'h1);
    chk("btb_target", {33'h0, imem_addr}, 65'h80);
    upd(32'h10, 0, 32'h0);
    upd(32'h10, 0, 32'h0);
    redir(32'h10);
    idle(); after_edge();
    chk("btb_pred_nt", {64'h0, fetch_dec_reg[0]}, 65'h0);
    chk("btb_fallthru", {33'h0, imem_addr}, 65'h14);

    // Reset asserted during stall, redirect and a taken update.
    @(negedge clk);
    rstn = 1'b0; stall = 1'b1; redirect_en = 1'b1; redirect_pc = 32'h200;
    upd_en = 1'b1; upd_pc = 32'h30; upd_taken = 1'b1; upd_target = 32'h90;
    model_reset();
    #1;
    chk("arst_fdr", fetch_dec_reg, 65'h0);
    chk("arst_pc", {33'h0, imem_addr}, {33'h0, RST_PC});
    repeat (3) @(posedge clk);
    #1;
    chk("rst_hold_pc", {33'h0, imem_addr}, {33'h0, RST_PC});
    idle(); after_edge();
    chk("rst_first_fetch", {33'h0, fetch_dec_reg[32:1]}, {33'h0, RST_PC});
    redir(32'h30);
    idle(); after_edge();
    chk("no_upd_in_reset", {64'h0, fetch_dec_reg[0]}, 65'h0);

    // Alias: same index, different tag.
    upd(32'h10, 1, 32'h80);
    redir(32'h10 + WIN);
    idle(); after_edge();
    chk("alias_pred", {64'h0, fetch_dec_reg[0]}, 65'h0);
    chk("alias_next", {33'h0, imem_addr}, {33'h0, 32'h10 + WIN + 32'd4});

    // Saturation: five taken then one not-taken still predicts taken.
    for (int i = 0; i < 5; i++) upd(32'h10, 1, 32'h80);
    upd(32'h10, 0, 32'h0);
    redir(32'h10);
    idle(); after_edge();
    chk("sat_pred", {64'h0, fetch_dec_reg[0]}, 65'h1);
    chk("sat_target", {33'h0, imem_addr}, 65'h80);

    // Wrap at top of address space; low redirect bits ignored.
    redir(32'hFFFF_FFFF);
    idle(); after_edge();
    chk("wrap_pc_field", {33'h0, fetch_dec_reg[32:1]}, {33'h0, 32'hFFFF_FFFC});
    chk("wrap_next", {33'h0, imem_addr}, 65'h0);

    // Random traffic.
    for (int i = 0; i < 3000; i++) begin
      step($urandom_range(0, 4) == 0,
           $urandom_range(0, 9) == 0,
           32'($urandom_range(0, 1023)),
           $urandom_range(0, 2) == 0,
           32'($urandom_range(0, 127)) * 32'd4,
           $urandom_range(0, 3) != 0,
           32'($urandom_range(0, 255)) * 32'd4);
    end

    for (int i = 0; i < 5 && q.size() > 0; i++) @(posedge clk);
    #3;
    if (q.size() != 0) begin
      nvec++;
      nerr++;
      $display("FAIL drain: %0d entries left, expected 0", q.size());
    end
    $display("== %0d vectors applied, %0d miscompares ==", nvec, nerr);
    $finish;
  end

endmodule

// File: doc/fetch_stage.md
FETCH_STAGE -- requirements
Module: fetch_stage

Interface
REQ-001 Parameter RESET_PC, default 32'h0000_0000, PC loaded on reset.
REQ-002 Parameter BTB_ENTRIES, default 16, power of two, branch target buffer depth; IDX = log2(BTB_ENTRIES).
REQ-003 clk  in  1  single clock; all state updates on rising edge.
REQ-004 rstn  in  1  asynchronous, active-low reset.
REQ-005 stall  in  1  hazard stall from decode; hold PC and output register.
REQ-006 redirect_en  in  1  mispredict or jump correction from execute.
REQ-007 redirect_pc  in  32  corrected fetch address.
REQ-008 upd_en  in  1  resolved control-transfer update for the BTB.
REQ-009 upd_pc  in  32  PC of the resolved branch.
REQ-010 upd_taken  in  1  resolved direction.
REQ-011 upd_target  in  32  resolved taken target.
REQ-012 imem_addr  out  32  instruction memory address; equals current PC combinationally.
REQ-013 imem_rdata  in  32  instruction word; combinational read, valid in the same cycle as imem_addr.
REQ-014 fetch_dec_reg  out  65  registered {instruction[31:0], pc[31:0], pred} to decode.

Function
REQ-015 PC register: 32 bits; bits [1:0] always 0; redirect_pc[1:0] ignored.
REQ-016 BTB entry: valid, tag = pc[31:IDX+2], target[31:0], 2-bit saturating counter; index = pc[IDX+1:2].
REQ-017 Lookup, combinational on current PC: hit = valid and tag match; pred = hit and counter[1].
REQ-018 next_pc = pred ? BTB target : PC + 4, modulo 2^32; 32'hFFFF_FFFC + 4 wraps to 0.
REQ-019 Cycle priority: redirect_en > stall > normal advance.
REQ-020 redirect_en = 1: PC <= redirect_pc; fetch_dec_reg <= 65'b0 (bubble); applies even when stall = 1.
REQ-021 stall = 1 and redirect_en = 0: PC and fetch_dec_reg hold their values.
REQ-022 Normal advance: fetch_dec_reg <= {imem_rdata, PC, pred}; PC <= next_pc; one-cycle latency from imem_addr to fetch_dec_reg.
REQ-023 BTB update on upd_en at the clock edge, independent of stall and redirect.
REQ-024 Update hit, i.e. valid and tag match at index(upd_pc): counter increments on taken and decrements on not-taken, saturating at 11 and 00; target <= upd_target when taken.
REQ-025 Update miss with upd_taken = 1: allocate with valid = 1, new tag, target = upd_target, counter = 10 (weakly taken).
REQ-026 Update miss with upd_taken = 0: no change to the BTB.
REQ-027 Same-cycle lookup and update of one index: the lookup uses the pre-edge contents; the new contents are visible next cycle.
REQ-028 The all-zero fetch_dec_reg is the bubble encoding; pred = 0 in every bubble.

Reset
REQ-029 rstn low asynchronously sets PC = RESET_PC and fetch_dec_reg = 65'b0, clears all BTB valid bits, and sets all counters to 01.
REQ-030 Reset during stall or redirect overrides both; the first fetch after release is at RESET_PC.
REQ-031 No BTB update is recorded while rstn is low.

Verification
REQ-032 Reset release with imem returning 32'h0000_0013 and no stall: after edge 1, fetch_dec_reg = {32'h13, 32'h0, 0}; after edge 2, pc field = 4.
REQ-033 stall held 3 cycles at PC = 8: imem_addr stays 8 and fetch_dec_reg does not change; on release the next entry has pc field = 8.
REQ-034 redirect_en with redirect_pc = 32'h40 while stall = 1: next cycle fetch_dec_reg = 0 and imem_addr = 32'h40.
REQ-035 upd_en taken at pc 32'h10 with target 32'h80, then fetch at 32'h10: pred = 1 and next imem_addr = 32'h80; after two not-taken updates, pred = 0 and next = 32'h14.
REQ-036 Alias: allocate an entry at 32'h10, then look up 32'h10 + 4*BTB_ENTRIES: tag miss, pred = 0, next = PC + 4.
REQ-037 Counter saturation: five taken updates, then one not-taken update: pred is still 1.
